// File: rtl/dpram_hs_pkg.sv
// Shared memory-family package: read-mode names and address-width helper.
package dpram_hs_pkg;

   localparam string RD_READ_FIRST  = "READ_FIRST";
   localparam string RD_WRITE_FIRST = "WRITE_FIRST";

   // Address width for a given depth, never below 1 bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/dpram_hs_port.sv
// Per-port read path: same-cycle write forwarding merge, latency pipeline, dout hold.
module dpram_hs_port #(
   parameter int  DW      = 32,
   parameter int  OUT_REG = 0,
   localparam int NB      = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd,
   input  logic [DW-1:0] rdata,
   input  logic [NB-1:0] fwd_wem,
   input  logic [DW-1:0] fwd_din,
   output logic          rvld,
   output logic [DW-1:0] dout
);

   localparam int STAGES = 1 + OUT_REG;

   logic [STAGES-1:0] vld_pipe;
   logic [DW-1:0]     merged;
   logic [DW-1:0]     d1;

   // fwd_wem is only non-zero in write-first mode with a colliding write.
   always_comb begin
      merged = rdata;
      for (int i = 0; i < NB; i++)
         if (fwd_wem[i]) merged[8*i +: 8] = fwd_din[8*i +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         d1       <= '0;
      end else begin
         vld_pipe <= (vld_pipe << 1) | STAGES'(rd);
         if (rd) d1 <= merged;
      end
   end

   assign rvld = vld_pipe[STAGES-1];

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DW-1:0] d2;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)           d2 <= '0;
            else if (vld_pipe[0]) d2 <= d1;
         end
         assign dout = d2;
      end else begin : g_noreg
         assign dout = d1;
      end
   endgenerate

endmodule

// File: rtl/dpram_hs.sv
// True dual-port RAM with byte masks, A-wins write collisions and optional output register.
// Define DPRAM_HS_COLL_CNT_EN to add the saturating 16-bit coll_cnt output.
module dpram_hs
   import dpram_hs_pkg::*;
#(
   parameter int    DW      = 32,
   parameter int    DEPTH   = 2048,
   parameter string RD_MODE = RD_READ_FIRST,
   parameter int    OUT_REG = 0,
   localparam int   AW      = clog2_min1(DEPTH),
   localparam int   NB      = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [NB-1:0] a_wem,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_din,
   output logic          a_rvld,
   output logic [DW-1:0] a_dout,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [NB-1:0] b_wem,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_din,
   output logic          b_rvld,
   output logic [DW-1:0] b_dout,
   output logic          coll
`ifdef DPRAM_HS_COLL_CNT_EN
   ,
   output logic [15:0]   coll_cnt
`endif
);

   localparam bit WF = (RD_MODE == RD_WRITE_FIRST);

   logic [DW-1:0] mem [DEPTH];

   logic          a_ok, b_ok, a_wr, b_wr, a_rd, b_rd, same, coll_now;
   logic [NB-1:0] a_bm, b_bm, a_fwm, b_fwm;
   logic [DW-1:0] a_q, b_q;

   // Out-of-range addresses only exist for non-power-of-2 depths.
   assign a_ok = ({1'b0, a_addr} < (AW+1)'(DEPTH));
   assign b_ok = ({1'b0, b_addr} < (AW+1)'(DEPTH));
   assign a_wr = a_req & a_we & a_ok;
   assign b_wr = b_req & b_we & b_ok;
   assign a_rd = a_req & ~a_we;
   assign b_rd = b_req & ~b_we;
   assign a_bm = a_wr ? a_wem : '0;
   assign b_bm = b_wr ? b_wem : '0;
   assign same = (a_addr == b_addr);

   assign a_q   = a_ok ? mem[a_addr] : '0;
   assign b_q   = b_ok ? mem[b_addr] : '0;
   assign a_fwm = (WF && same) ? b_bm : '0;
   assign b_fwm = (WF && same) ? a_bm : '0;

   assign coll_now = same & (|(a_bm & b_bm));

   // Port A is applied last so it wins on overlapping bytes.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (b_bm[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
         if (a_bm[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) coll <= 1'b0;
      else        coll <= coll_now;
   end

`ifdef DPRAM_HS_COLL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           coll_cnt <= '0;
      else if (coll && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
   end
`endif

   dpram_hs_port #(.DW(DW), .OUT_REG(OUT_REG)) u_port_a (
      .clk(clk), .rst_n(rst_n), .rd(a_rd), .rdata(a_q), .fwd_wem(a_fwm),
      .fwd_din(b_din), .rvld(a_rvld), .dout(a_dout)
   );

   dpram_hs_port #(.DW(DW), .OUT_REG(OUT_REG)) u_port_b (
      .clk(clk), .rst_n(rst_n), .rd(b_rd), .rdata(b_q), .fwd_wem(b_fwm),
      .fwd_din(a_din), .rvld(b_rvld), .dout(b_dout)
   );

endmodule

// File: tb/tb_dpram_hs.sv
// Bench: READ_FIRST/OUT_REG=1 and WRITE_FIRST/OUT_REG=0 instances on shared stimulus, DEPTH=100.
module tb_dpram_hs;

   localparam int DW = 32, DEPTH = 100, AW = 7, NB = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_req, a_we, b_req, b_we;
   logic [NB-1:0] a_wem, b_wem;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_din, b_din;

   logic          rf_a_rvld, rf_b_rvld, rf_coll, wf_a_rvld, wf_b_rvld, wf_coll;
   logic [DW-1:0] rf_a_dout, rf_b_dout, wf_a_dout, wf_b_dout;
`ifdef DPRAM_HS_COLL_CNT_EN
   logic [15:0]   rf_cnt, wf_cnt;
`endif

   dpram_hs #(.DW(DW), .DEPTH(DEPTH), .RD_MODE("READ_FIRST"), .OUT_REG(1)) u_rf (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_wem(a_wem), .a_addr(a_addr), .a_din(a_din),
      .a_rvld(rf_a_rvld), .a_dout(rf_a_dout),
      .b_req(b_req), .b_we(b_we), .b_wem(b_wem), .b_addr(b_addr), .b_din(b_din),
      .b_rvld(rf_b_rvld), .b_dout(rf_b_dout),
      .coll(rf_coll)
`ifdef DPRAM_HS_COLL_CNT_EN
      , .coll_cnt(rf_cnt)
`endif
   );

   dpram_hs #(.DW(DW), .DEPTH(DEPTH), .RD_MODE("WRITE_FIRST"), .OUT_REG(0)) u_wf (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_wem(a_wem), .a_addr(a_addr), .a_din(a_din),
      .a_rvld(wf_a_rvld), .a_dout(wf_a_dout),
      .b_req(b_req), .b_we(b_we), .b_wem(b_wem), .b_addr(b_addr), .b_din(b_din),
      .b_rvld(wf_b_rvld), .b_dout(wf_b_dout),
      .coll(wf_coll)
`ifdef DPRAM_HS_COLL_CNT_EN
      , .coll_cnt(wf_cnt)
`endif
   );

   typedef struct {
      logic          a_req, a_we;
      logic [NB-1:0] a_wem;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_din;
      logic          b_req, b_we;
      logic [NB-1:0] b_wem;
      logic [AW-1:0] b_addr;
      logic [DW-1:0] b_din;
      logic [DW-1:0] x_a_rf, x_a_wf, x_b_rf, x_b_wf;
      logic          x_coll;
   } vec_t;

   int errors = 0, checks = 0;

   // Reference model: word array plus expected output state per instance.
   logic [DW-1:0] mm [DEPTH];
   bit            pv [2];
   logic [DW-1:0] pd [2];
   bit            e_rf_v [2], e_wf_v [2];
   logic [DW-1:0] e_rf_d [2], e_wf_d [2];
   bit            e_coll;
   int            e_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         pv[p] = 0; pd[p] = '0; e_rf_v[p] = 0; e_wf_v[p] = 0; e_rf_d[p] = '0; e_wf_d[p] = '0;
      end
      e_coll = 0; e_cnt = 0;
   endtask

   task automatic set_in(input vec_t v);
      a_req = v.a_req; a_we = v.a_we; a_wem = v.a_wem; a_addr = v.a_addr; a_din = v.a_din;
      b_req = v.b_req; b_we = v.b_we; b_wem = v.b_wem; b_addr = v.b_addr; b_din = v.b_din;
   endtask

   task automatic idle();
      a_req = 0; a_we = 0; a_wem = '0; a_addr = '0; a_din = '0;
      b_req = 0; b_we = 0; b_wem = '0; b_addr = '0; b_din = '0;
   endtask

   // One clock: model consumes the inputs held across the edge, then all outputs are compared.
   task automatic cycle();
      bit            rd [2], wr [2];
      logic [AW-1:0] ad [2];
      logic [NB-1:0] wm [2];
      logic [DW-1:0] dn [2], rfv [2], wfv [2], w;
      @(posedge clk); #1;
      rd[0] = a_req && !a_we; wr[0] = a_req && a_we && (a_addr < DEPTH);
      rd[1] = b_req && !b_we; wr[1] = b_req && b_we && (b_addr < DEPTH);
      ad[0] = a_addr; ad[1] = b_addr; wm[0] = a_wem; wm[1] = b_wem; dn[0] = a_din; dn[1] = b_din;
      for (int p = 0; p < 2; p++) begin
         rfv[p] = (ad[p] < DEPTH) ? mm[ad[p]] : '0;
         wfv[p] = rfv[p];
         if (wr[1-p] && ad[1-p] == ad[p])
            for (int i = 0; i < NB; i++)
               if (wm[1-p][i]) wfv[p][8*i +: 8] = dn[1-p][8*i +: 8];
      end
      for (int p = 0; p < 2; p++) begin
         e_wf_v[p] = rd[p];
         if (rd[p]) e_wf_d[p] = wfv[p];
         e_rf_v[p] = pv[p];
         if (pv[p]) e_rf_d[p] = pd[p];
         pv[p] = rd[p]; pd[p] = rfv[p];
      end
      if (e_coll && e_cnt < 65535) e_cnt++;
      e_coll = wr[0] && wr[1] && ad[0] == ad[1] && ((wm[0] & wm[1]) != 0);
      for (int p = 1; p >= 0; p--)
         if (wr[p]) begin
            w = mm[ad[p]];
            for (int i = 0; i < NB; i++) if (wm[p][i]) w[8*i +: 8] = dn[p][8*i +: 8];
            mm[ad[p]] = w;
         end
      chk("rf_a_rvld", rf_a_rvld, e_rf_v[0]); chk("rf_a_dout", rf_a_dout, e_rf_d[0]);
      chk("rf_b_rvld", rf_b_rvld, e_rf_v[1]); chk("rf_b_dout", rf_b_dout, e_rf_d[1]);
      chk("wf_a_rvld", wf_a_rvld, e_wf_v[0]); chk("wf_a_dout", wf_a_dout, e_wf_d[0]);
      chk("wf_b_rvld", wf_b_rvld, e_wf_v[1]); chk("wf_b_dout", wf_b_dout, e_wf_d[1]);
      chk("rf_coll", rf_coll, e_coll);        chk("wf_coll", wf_coll, e_coll);
`ifdef DPRAM_HS_COLL_CNT_EN
      chk("rf_coll_cnt", rf_cnt, e_cnt);      chk("wf_coll_cnt", wf_cnt, e_cnt);
`endif
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, "_rf_a_rvld"}, rf_a_rvld, 0); chk({nm, "_rf_a_dout"}, rf_a_dout, 0);
      chk({nm, "_rf_b_rvld"}, rf_b_rvld, 0); chk({nm, "_rf_b_dout"}, rf_b_dout, 0);
      chk({nm, "_wf_a_rvld"}, wf_a_rvld, 0); chk({nm, "_wf_a_dout"}, wf_a_dout, 0);
      chk({nm, "_wf_b_rvld"}, wf_b_rvld, 0); chk({nm, "_wf_b_dout"}, wf_b_dout, 0);
      chk({nm, "_rf_coll"}, rf_coll, 0);     chk({nm, "_wf_coll"}, wf_coll, 0);
`ifdef DPRAM_HS_COLL_CNT_EN
      chk({nm, "_rf_cnt"}, rf_cnt, 0);       chk({nm, "_wf_cnt"}, wf_cnt, 0);
`endif
   endtask

   vec_t tbl [12];
   int   na, nb;

   initial begin
      //           a: req we wem  addr    din          b: req we wem  addr    din           a_rf          a_wf          b_rf          b_wf         coll
      tbl[0]  = '{1, 1, 4'hF, 7'd5,  32'h11223344, 0, 0, 4'h0, 7'd0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0};
      tbl[1]  = '{1, 0, 4'h0, 7'd5,  32'h0,        0, 0, 4'h0, 7'd0,   32'h0,        32'h11223344, 32'h11223344, 32'h0,        32'h0,        0};
      tbl[2]  = '{1, 1, 4'hF, 7'd7,  32'h0,        0, 0, 4'h0, 7'd0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0};
      tbl[3]  = '{1, 1, 4'h3, 7'd7,  32'hAAAAAAAA, 1, 1, 4'h6, 7'd7,   32'hBBBBBBBB, 32'h0,        32'h0,        32'h0,        32'h0,        1};
      tbl[4]  = '{1, 0, 4'h0, 7'd7,  32'h0,        0, 0, 4'h0, 7'd0,   32'h0,        32'h00BBAAAA, 32'h00BBAAAA, 32'h0,        32'h0,        0};
      tbl[5]  = '{1, 1, 4'hF, 7'd9,  32'h12345678, 0, 0, 4'h0, 7'd0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0};
      tbl[6]  = '{1, 0, 4'h0, 7'd9,  32'h0,        1, 1, 4'h8, 7'd9,   32'hFFFFFFFF, 32'h12345678, 32'hFF345678, 32'h0,        32'h0,        0};
      tbl[7]  = '{0, 0, 4'h0, 7'd0,  32'h0,        1, 0, 4'h0, 7'd9,   32'h0,        32'h0,        32'h0,        32'hFF345678, 32'hFF345678, 0};
      tbl[8]  = '{1, 1, 4'h0, 7'd5,  32'h0,        1, 1, 4'hF, 7'd5,   32'h55667788, 32'h0,        32'h0,        32'h0,        32'h0,        0};
      tbl[9]  = '{1, 0, 4'h0, 7'd5,  32'h0,        0, 0, 4'h0, 7'd0,   32'h0,        32'h55667788, 32'h55667788, 32'h0,        32'h0,        0};
      tbl[10] = '{1, 1, 4'hF, 7'd99, 32'hCAFEF00D, 1, 1, 4'hF, 7'd100, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        0};
      tbl[11] = '{1, 0, 4'h0, 7'd99, 32'h0,        1, 0, 4'h0, 7'd100, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0,        0};

      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1 chk_reset_state("reset");
      @(negedge clk) rst_n = 1'b1;

      // Give every word a known value so the model never depends on uninitialised RAM.
      for (int i = 0; i < DEPTH / 2; i++) begin
         a_req = 1; a_we = 1; a_wem = 4'hF; a_addr = AW'(i);           a_din = $urandom;
         b_req = 1; b_we = 1; b_wem = 4'hF; b_addr = AW'(i + DEPTH/2); b_din = $urandom;
         cycle();
      end

      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i]);
         cycle();
         if (tbl[i].a_req && !tbl[i].a_we) begin
            chk($sformatf("tbl%0d_wf_a_rvld", i), wf_a_rvld, 1);
            chk($sformatf("tbl%0d_wf_a_dout", i), wf_a_dout, tbl[i].x_a_wf);
         end
         if (tbl[i].b_req && !tbl[i].b_we) begin
            chk($sformatf("tbl%0d_wf_b_rvld", i), wf_b_rvld, 1);
            chk($sformatf("tbl%0d_wf_b_dout", i), wf_b_dout, tbl[i].x_b_wf);
         end
         chk($sformatf("tbl%0d_rf_coll", i), rf_coll, tbl[i].x_coll);
         chk($sformatf("tbl%0d_wf_coll", i), wf_coll, tbl[i].x_coll);
         idle();
         cycle();
         if (tbl[i].a_req && !tbl[i].a_we) begin
            chk($sformatf("tbl%0d_rf_a_rvld", i), rf_a_rvld, 1);
            chk($sformatf("tbl%0d_rf_a_dout", i), rf_a_dout, tbl[i].x_a_rf);
         end
         if (tbl[i].b_req && !tbl[i].b_we) begin
            chk($sformatf("tbl%0d_rf_b_rvld", i), rf_b_rvld, 1);
            chk($sformatf("tbl%0d_rf_b_dout", i), rf_b_dout, tbl[i].x_b_rf);
         end
      end

      // Random traffic concentrated on a few addresses, including out-of-range ones.
      for (int n = 0; n < 800; n++) begin
         int r;
         r = $urandom_range(0, 9);
         a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1); a_wem = NB'($urandom);
         a_addr = (r < 8) ? AW'(r) : (r == 8 ? 7'd99 : AW'($urandom_range(100, 127)));
         a_din = $urandom;
         r = $urandom_range(0, 9);
         b_req = ($urandom_range(0, 3) != 0); b_we = $urandom_range(0, 1); b_wem = NB'($urandom);
         b_addr = (r < 8) ? AW'(r) : (r == 8 ? 7'd99 : AW'($urandom_range(100, 127)));
         b_din = $urandom;
         cycle();
      end

      // Full-rate reads on both ports: 64 pulses each, no gaps.
      na = 0; nb = 0;
      for (int i = 0; i < 66; i++) begin
         if (i < 64) begin
            a_req = 1; a_we = 0; a_addr = AW'(i);
            b_req = 1; b_we = 0; b_addr = AW'(63 - i);
         end else idle();
         cycle();
         if (i >= 1 && i <= 64) begin
            chk("b2b_rf_a_gap", rf_a_rvld, 1);
            chk("b2b_rf_b_gap", rf_b_rvld, 1);
         end
         na += int'(rf_a_rvld); nb += int'(rf_b_rvld);
      end
      chk("b2b_rf_a_count", na, 64);
      chk("b2b_rf_b_count", nb, 64);

      // Read in flight when reset asserts is dropped; RAM keeps its contents.
      a_req = 1; a_we = 0; a_addr = 7'd9; b_req = 1; b_we = 0; b_addr = 7'd7;
      cycle();
      #1 rst_n = 1'b0;
      idle();
      #1 chk_reset_state("midreset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("post_reset_rf_a_rvld", rf_a_rvld, 0);
      end
      a_req = 1; a_we = 0; a_addr = 7'd99;
      cycle();
      idle();
      cycle();
      chk("retain_rf_a_dout", rf_a_dout, mm[99]);

`ifdef DPRAM_HS_COLL_CNT_EN
      // Saturate the collision counter, then one more collision must not wrap it.
      a_req = 1; a_we = 1; a_wem = 4'h1; a_addr = 7'd3; a_din = 32'h1;
      b_req = 1; b_we = 1; b_wem = 4'h1; b_addr = 7'd3; b_din = 32'h2;
      for (int i = 0; i < 65535; i++) cycle();
      idle();
      cycle();
      chk("sat_rf_cnt", rf_cnt, 32'hFFFF);
      a_req = 1; a_we = 1; a_wem = 4'h1; a_addr = 7'd3;
      b_req = 1; b_we = 1; b_wem = 4'h1; b_addr = 7'd3;
      cycle();
      idle();
      cycle();
      cycle();
      chk("sat_hold_rf_cnt", rf_cnt, 32'hFFFF);
      chk("sat_hold_wf_cnt", wf_cnt, 32'hFFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
